down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 83 ++++++++
 tb/tb_down_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down counter with IDLE/RUN/DONE control, a one-cycle done pulse
// and an optional automatic restart from the last loaded value.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] count_dec_next;
  logic [WIDTH-1:0] borrow;

  // Ripple-borrow decrement: bit gi flips when every lower bit is zero.
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign count_dec_next[gi] = count_reg[gi] ^ borrow[gi];
      if (gi < WIDTH - 1) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] & ~count_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
    end else if (load) begin
      count_reg  <= load_val;
      reload_reg <= load_val;
      state_reg  <= (load_val != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        IDLE: state_reg <= IDLE;
        RUN: begin
          if (en) begin
            // Reaching (or somehow sitting at) 1 ends the run; never wrap below 0.
            if (count_reg <= WIDTH'(1)) begin
              count_reg <= '0;
              state_reg <= DONE;
            end else begin
              count_reg <= count_dec_next;
            end
          end
        end
        DONE: begin
          if (auto_reload && (reload_reg != '0)) begin
            count_reg <= reload_reg;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: directed vector table, latency sweep, and random
// stimulus compared against an arithmetic reference model.
module tb_down_counter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         zero;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model state: value, whether a countdown is active, done pulse.
  int m_count  = 0;
  int m_reload = 0;
  bit m_busy   = 0;
  bit m_done   = 0;

  typedef struct {
    bit     rst;
    bit     load;
    int     lv;
    bit     en;
    bit     ar;
    int     exp_count;
    bit     exp_zero;
    bit     exp_busy;
    bit     exp_done;
  } vec_t;

  vec_t vecs[$];

  down_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .zero        (zero),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behaviour from the rules: reset wins, then load, then the done cycle
  // (restart or stop), then an enabled countdown step.
  task automatic model_update();
    if (rst) begin
      m_count = 0; m_reload = 0; m_busy = 0; m_done = 0;
    end else if (load) begin
      m_count  = int'(load_val);
      m_reload = int'(load_val);
      m_busy   = (m_count != 0);
      m_done   = 0;
    end else if (m_done) begin
      m_done = 0;
      if (auto_reload && m_reload != 0) begin
        m_count = m_reload;
        m_busy  = 1;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy && en) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit ld, input int lv, input bit e, input bit ar);
    rst = r; load = ld; load_val = W'(lv); en = e; auto_reload = ar;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic add(input bit r, input bit ld, input int lv, input bit e, input bit ar,
                     input int c, input bit z, input bit b, input bit d);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = lv; v.en = e; v.ar = ar;
    v.exp_count = c; v.exp_zero = z; v.exp_busy = b; v.exp_done = d;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

    //  rst ld lv en ar   count zero busy done
    add(1, 1, 7, 1, 0,    0, 1, 0, 0);   // reset beats load and en
    add(1, 0, 0, 0, 0,    0, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);   // idle ignores en, no wrap
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 1, 3, 0, 0,    3, 0, 1, 0);   // basic countdown
    add(0, 0, 0, 1, 0,    2, 0, 1, 0);
    add(0, 0, 0, 1, 0,    1, 0, 1, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 1);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 1, 15, 0, 0,  15, 0, 1, 0);   // stall at max value
    add(0, 0, 0, 1, 0,   14, 0, 1, 0);
    add(0, 0, 0, 0, 0,   14, 0, 1, 0);
    add(0, 0, 0, 0, 0,   14, 0, 1, 0);
    add(0, 0, 0, 1, 0,   13, 0, 1, 0);
    add(0, 1, 0, 1, 0,    0, 1, 0, 0);   // zero load goes idle
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);
    add(0, 1, 2, 0, 1,    2, 0, 1, 0);   // periodic auto-reload
    add(0, 0, 0, 1, 1,    1, 0, 1, 0);
    add(0, 0, 0, 1, 1,    0, 1, 0, 1);
    add(0, 0, 0, 1, 1,    2, 0, 1, 0);
    add(0, 0, 0, 1, 1,    1, 0, 1, 0);
    add(0, 0, 0, 1, 1,    0, 1, 0, 1);
    add(0, 0, 0, 1, 1,    2, 0, 1, 0);
    add(0, 0, 0, 1, 1,    1, 0, 1, 0);
    add(0, 0, 0, 1, 1,    0, 1, 0, 1);
    add(0, 1, 9, 1, 1,    9, 0, 1, 0);   // load in done beats auto-reload
    add(0, 1, 6, 1, 0,    6, 0, 1, 0);   // load in run, no decrement
    add(0, 0, 0, 1, 0,    5, 0, 1, 0);
    add(1, 0, 0, 1, 1,    0, 1, 0, 0);   // reset mid-run at 5
    add(0, 0, 0, 1, 1,    0, 1, 0, 0);
    add(0, 0, 0, 1, 1,    0, 1, 0, 0);
    add(0, 1, 1, 0, 0,    1, 0, 1, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 1);
    add(1, 0, 0, 0, 1,    0, 1, 0, 0);   // reset during done
    add(0, 1, 1, 1, 0,    1, 0, 1, 0);
    add(0, 0, 0, 1, 0,    0, 1, 0, 1);
    add(0, 0, 0, 0, 1,    1, 0, 1, 0);   // auto_reload seen only in done
    add(0, 0, 0, 1, 0,    0, 1, 0, 1);
    add(0, 0, 0, 1, 0,    0, 1, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].ar);
      $display("vec %0d: rst=%0b load=%0b lv=%0d en=%0b ar=%0b -> count=%0d zero=%0b busy=%0b done=%0b",
               i, vecs[i].rst, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].ar,
               count, zero, busy, done);
      check($sformatf("vec%0d_count", i), 8'(count), 8'(vecs[i].exp_count));
      check($sformatf("vec%0d_zero", i),  8'(zero),  8'(vecs[i].exp_zero));
      check($sformatf("vec%0d_busy", i),  8'(busy),  8'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i),  8'(done),  8'(vecs[i].exp_done));
    end

    // Latency sweep: done appears N edges after the loading edge.
    for (int n = 1; n < 16; n++) begin
      int seen;
      seen = 99;
      step(1, 0, 0, 0, 0);
      step(0, 1, n, 1, 0);
      for (int k = 1; k <= 40; k++) begin
        step(0, 0, 0, 1, 0);
        if (done === 1'b1) begin
          seen = k;
          break;
        end
      end
      $display("latency N=%0d: done after %0d edges", n, seen);
      check($sformatf("latency_n%0d", n), 8'(seen), 8'(n));
      step(0, 0, 0, 1, 0);
      check($sformatf("latency_n%0d_done_width", n), 8'(done), 8'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 1000; c++) begin
      bit r, ld, e, ar;
      int lv;
      r  = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 9) < 7);
      ar = $urandom_range(0, 1) == 1;
      lv = $urandom_range(0, 15);
      step(r, ld, lv, e, ar);
      $display("rand %0d: rst=%0b load=%0b lv=%0d en=%0b ar=%0b -> count=%0d zero=%0b busy=%0b done=%0b",
               c, r, ld, lv, e, ar, count, zero, busy, done);
      check("rand_count", 8'(count), 8'(m_count));
      check("rand_zero",  8'(zero),  8'(m_count == 0));
      check("rand_busy",  8'(busy),  8'(m_busy));
      check("rand_done",  8'(done),  8'(m_done));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
